// File: rtl/bus_transfer_seq.sv
// Bus transfer sequencer: moves one word from a source register to a destination register
// over the shared data bus using one-hot output enables (eo) and input enables (ei).
module bus_transfer_seq #(
  parameter int NREGS = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDXW-1:0]  req_src,
  input  logic [IDXW-1:0]  req_dst,
  input  logic             req_rd_only,
  input  logic [WIDTH-1:0] bus_in,
  output logic [NREGS-1:0] eo,
  output logic [NREGS-1:0] ei,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             err,
  output logic             busy,
  output logic [7:0]       xfer_count
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_LATCH, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDXW-1:0]  r_src, r_dst;
  logic             r_wr;
  logic [NREGS-1:0] r_eo, w_eo_nxt, r_ei;
  logic             r_rd_valid, w_rd_valid_nxt;
  logic             r_err, w_err_nxt;
  logic [WIDTH-1:0] r_rd_data;
  logic [7:0]       r_xfer_count;
  logic             w_accept, w_bad;

  function automatic logic [NREGS-1:0] f_onehot(input logic [IDXW-1:0] idx);
    logic [NREGS-1:0] oh;
    for (int k = 0; k < NREGS; k++) oh[k] = (int'(idx) == k);
    return oh;
  endfunction

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_bad    = (int'(req_src) >= NREGS) || (!req_rd_only && (int'(req_dst) >= NREGS));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_bad ? S_DONE : S_DRIVE;
      S_DRIVE: w_state_nxt = r_wr ? S_LATCH : S_DONE;
      S_LATCH: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed for the state being entered and registered on the same edge.
  always_comb begin
    w_eo_nxt       = '0;
    w_rd_valid_nxt = 1'b0;
    w_err_nxt      = 1'b0;
    if (w_state_nxt == S_DRIVE && r_state == S_IDLE) w_eo_nxt = f_onehot(req_src);
    else if (w_state_nxt == S_LATCH)                 w_eo_nxt = r_eo;
    if (w_state_nxt == S_DONE) begin
      w_err_nxt      = (r_state == S_IDLE);
      w_rd_valid_nxt = (r_state != S_IDLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src        <= '0;
      r_dst        <= '0;
      r_wr         <= 1'b0;
      r_eo         <= '0;
      r_rd_valid   <= 1'b0;
      r_err        <= 1'b0;
      r_rd_data    <= '0;
      r_xfer_count <= '0;
    end else begin
      if (w_accept) begin
        r_src <= req_src;
        r_dst <= req_dst;
        r_wr  <= !req_rd_only && (req_dst != req_src);
      end
      r_eo       <= w_eo_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_err      <= w_err_nxt;
      if (r_state == S_DRIVE) r_rd_data <= bus_in;
      if (r_state == S_LATCH) r_xfer_count <= r_xfer_count + 8'd1;
    end
  end

  // ei launches on the falling edge so clk&ei has exactly one clean high phase, ending LATCH.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) r_ei <= '0;
    else       r_ei <= (r_state == S_LATCH) ? f_onehot(r_dst) : '0;
  end

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign eo         = r_eo;
  assign ei         = r_ei;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign err        = r_err;
  assign xfer_count = r_xfer_count;

  // The source index is only used to build eo at accept time; keep it for debug visibility.
  logic w_unused_src;
  assign w_unused_src = ^r_src;

endmodule

// File: tb/tb_bus_transfer_seq.sv
// Directed bench for bus_transfer_seq: a 4-register bank with gated-enable capture,
// plus a 3-register instance for out-of-range index handling.
module tb_bus_transfer_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       req_valid, req_ready, req_rd_only;
  logic [1:0] req_src, req_dst;
  logic [7:0] bus_in, rd_data, xfer_count;
  logic [3:0] eo, ei;
  logic       rd_valid, err, busy;

  logic       d3_req_valid, d3_req_ready, d3_req_rd_only;
  logic [1:0] d3_req_src, d3_req_dst;
  logic [7:0] d3_bus_in, d3_rd_data, d3_xfer_count;
  logic [2:0] d3_eo, d3_ei;
  logic       d3_rd_valid, d3_err, d3_busy;

  logic [7:0] src_val [4];
  logic [7:0] regq [4];
  logic       tb_init;
  int         ei_edges = 0;
  int         multihot = 0;
  int         total = 0;
  int         bad = 0;

  bus_transfer_seq #(.NREGS(4), .WIDTH(8), .IDXW(2)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .req_rd_only(req_rd_only), .bus_in(bus_in),
    .eo(eo), .ei(ei), .rd_data(rd_data), .rd_valid(rd_valid), .err(err), .busy(busy),
    .xfer_count(xfer_count)
  );

  bus_transfer_seq #(.NREGS(3), .WIDTH(8), .IDXW(2)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(d3_req_valid), .req_ready(d3_req_ready),
    .req_src(d3_req_src), .req_dst(d3_req_dst), .req_rd_only(d3_req_rd_only), .bus_in(d3_bus_in),
    .eo(d3_eo), .ei(d3_ei), .rd_data(d3_rd_data), .rd_valid(d3_rd_valid), .err(d3_err),
    .busy(d3_busy), .xfer_count(d3_xfer_count)
  );

  // Bus mux driven by eo; register bank captures the bus on clock edges where its EI is high.
  always_comb begin
    bus_in = '0;
    for (int k = 0; k < 4; k++) if (eo[k]) bus_in = bus_in | src_val[k];
    d3_bus_in = '0;
    for (int k = 0; k < 3; k++) if (d3_eo[k]) d3_bus_in = d3_bus_in | (8'h70 + 8'(k));
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (tb_init)    regq[k] <= 8'h10 + 8'(k);
      else if (ei[k]) regq[k] <= bus_in;
    end
    if (ei != 4'b0) ei_edges <= ei_edges + 1;
    if (!$onehot0(eo) || !$onehot0(ei)) multihot <= multihot + 1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    total++; if (eo !== 4'b0)    begin bad++; $display("FAIL rst_eo: got %b want 0000", eo); end
    total++; if (ei !== 4'b0)    begin bad++; $display("FAIL rst_ei: got %b want 0000", ei); end
    total++; if (rd_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL rst_flags: got rv=%b err=%b busy=%b want 0 0 0", rd_valid, err, busy); end
    total++; if (rd_data !== 8'h00 || xfer_count !== 8'h00)
      begin bad++; $display("FAIL rst_data_cnt: got %h %h want 00 00", rd_data, xfer_count); end
    @(posedge clk); #1;
    tb_init = 1'b0;
    @(negedge clk); reset = 1'b0;
    tick();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_write();
    int e0;
    e0 = ei_edges;
    src_val[1] = 8'hA5;
    req_valid = 1'b1; req_src = 2'd1; req_dst = 2'd2; req_rd_only = 1'b0;
    tick();
    req_valid = 1'b0;
    total++; if (eo !== 4'b0010) begin bad++; $display("FAIL wr_eo_c1: got %b want 0010", eo); end
    total++; if (busy !== 1'b1 || req_ready !== 1'b0)
      begin bad++; $display("FAIL wr_busy_c1: got busy=%b ready=%b want 1 0", busy, req_ready); end
    tick();
    total++; if (eo !== 4'b0010 || ei !== 4'b0) begin bad++; $display("FAIL wr_c2: got eo=%b ei=%b want 0010 0000", eo, ei); end
    @(negedge clk); #1;
    total++; if (ei !== 4'b0100) begin bad++; $display("FAIL wr_ei_high: got %b want 0100", ei); end
    tick();
    total++; if (eo !== 4'b0 || rd_valid !== 1'b1 || rd_data !== 8'hA5)
      begin bad++; $display("FAIL wr_c3: got eo=%b rv=%b data=%h want 0000 1 a5", eo, rd_valid, rd_data); end
    total++; if (regq[2] !== 8'hA5) begin bad++; $display("FAIL wr_reg2: got %h want a5", regq[2]); end
    total++; if (xfer_count !== 8'd1) begin bad++; $display("FAIL wr_count: got %0d want 1", xfer_count); end
    @(negedge clk); #1;
    total++; if (ei !== 4'b0) begin bad++; $display("FAIL wr_ei_low: got %b want 0000", ei); end
    tick();
    total++; if (rd_valid !== 1'b0 || req_ready !== 1'b1 || ei_edges - e0 !== 1)
      begin bad++; $display("FAIL wr_end: got rv=%b ready=%b ei_edges=%0d want 0 1 1", rd_valid, req_ready, ei_edges - e0); end
  endtask

  task automatic test_read_only();
    int e0;
    e0 = ei_edges;
    src_val[3] = 8'h3C;
    req_valid = 1'b1; req_src = 2'd3; req_dst = 2'd0; req_rd_only = 1'b1;
    tick();
    req_valid = 1'b0;
    total++; if (eo !== 4'b1000) begin bad++; $display("FAIL rd_eo_c1: got %b want 1000", eo); end
    tick();
    total++; if (eo !== 4'b0 || rd_valid !== 1'b1 || rd_data !== 8'h3C)
      begin bad++; $display("FAIL rd_c2: got eo=%b rv=%b data=%h want 0000 1 3c", eo, rd_valid, rd_data); end
    total++; if (xfer_count !== 8'd1) begin bad++; $display("FAIL rd_count: got %0d want 1", xfer_count); end
    tick();
    total++; if (req_ready !== 1'b1 || ei_edges - e0 !== 0)
      begin bad++; $display("FAIL rd_end: got ready=%b ei_edges=%0d want 1 0", req_ready, ei_edges - e0); end
  endtask

  task automatic test_same_src_dst();
    int e0;
    e0 = ei_edges;
    src_val[0] = 8'h5A;
    req_valid = 1'b1; req_src = 2'd0; req_dst = 2'd0; req_rd_only = 1'b0;
    tick();
    req_valid = 1'b0;
    total++; if (eo !== 4'b0001) begin bad++; $display("FAIL same_eo_c1: got %b want 0001", eo); end
    tick();
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h5A || eo !== 4'b0)
      begin bad++; $display("FAIL same_c2: got rv=%b data=%h eo=%b want 1 5a 0000", rd_valid, rd_data, eo); end
    tick();
    total++; if (regq[0] !== 8'h10 || xfer_count !== 8'd1 || ei_edges - e0 !== 0)
      begin bad++; $display("FAIL same_end: got reg0=%h cnt=%0d ei_edges=%0d want 10 1 0", regq[0], xfer_count, ei_edges - e0); end
  endtask

  task automatic test_err();
    d3_req_valid = 1'b1; d3_req_src = 2'd3; d3_req_dst = 2'd0; d3_req_rd_only = 1'b1;
    tick();
    d3_req_valid = 1'b0;
    total++; if (d3_err !== 1'b1 || d3_rd_valid !== 1'b0 || d3_eo !== 3'b0 || d3_ei !== 3'b0)
      begin bad++; $display("FAIL err_src_c1: got err=%b rv=%b eo=%b ei=%b want 1 0 000 000", d3_err, d3_rd_valid, d3_eo, d3_ei); end
    tick();
    total++; if (d3_err !== 1'b0 || d3_req_ready !== 1'b1)
      begin bad++; $display("FAIL err_src_c2: got err=%b ready=%b want 0 1", d3_err, d3_req_ready); end
    d3_req_valid = 1'b1; d3_req_src = 2'd0; d3_req_dst = 2'd3; d3_req_rd_only = 1'b0;
    tick();
    d3_req_valid = 1'b0;
    total++; if (d3_err !== 1'b1 || d3_eo !== 3'b0)
      begin bad++; $display("FAIL err_dst_c1: got err=%b eo=%b want 1 000", d3_err, d3_eo); end
    tick();
    d3_req_valid = 1'b1; d3_req_src = 2'd2; d3_req_dst = 2'd3; d3_req_rd_only = 1'b1;
    tick();
    d3_req_valid = 1'b0;
    total++; if (d3_eo !== 3'b100) begin bad++; $display("FAIL err_next_eo: got %b want 100", d3_eo); end
    tick();
    total++; if (d3_rd_valid !== 1'b1 || d3_rd_data !== 8'h72 || d3_err !== 1'b0 || d3_xfer_count !== 8'd0)
      begin bad++; $display("FAIL err_next_rd: got rv=%b data=%h err=%b cnt=%0d want 1 72 0 0", d3_rd_valid, d3_rd_data, d3_err, d3_xfer_count); end
    tick();
  endtask

  task automatic test_reset_mid_latch();
    src_val[1] = 8'hEE;
    req_valid = 1'b1; req_src = 2'd1; req_dst = 2'd3; req_rd_only = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    @(negedge clk); #1;
    total++; if (ei !== 4'b1000) begin bad++; $display("FAIL rml_ei_before: got %b want 1000", ei); end
    reset = 1'b1;
    #1;
    total++; if (ei !== 4'b0 || eo !== 4'b0 || xfer_count !== 8'd0 || busy !== 1'b0)
      begin bad++; $display("FAIL rml_drop: got ei=%b eo=%b cnt=%0d busy=%b want 0000 0000 0 0", ei, eo, xfer_count, busy); end
    tick();
    total++; if (regq[3] !== 8'h13) begin bad++; $display("FAIL rml_reg3: got %h want 13", regq[3]); end
    @(negedge clk); reset = 1'b0;
    tick();
    total++; if (req_ready !== 1'b1 || xfer_count !== 8'd0)
      begin bad++; $display("FAIL rml_after: got ready=%b cnt=%0d want 1 0", req_ready, xfer_count); end
  endtask

  task automatic test_back_to_back();
    int e0, ready_bad, ready_ones, mh0;
    logic [7:0] cnt_at_last;
    e0 = ei_edges; mh0 = multihot; ready_bad = 0; ready_ones = 0; cnt_at_last = 8'h00;
    src_val[0] = 8'hC3;
    req_valid = 1'b1; req_src = 2'd0; req_dst = 2'd1; req_rd_only = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      if (req_ready !== (i % 4 == 0)) ready_bad++;
      if (req_ready === 1'b1) ready_ones++;
      if (i == 1020) cnt_at_last = xfer_count;
      tick();
    end
    req_valid = 1'b0;
    total++; if (ready_bad !== 0 || ready_ones !== 256)
      begin bad++; $display("FAIL b2b_ready: got bad_cycles=%0d ones=%0d want 0 256", ready_bad, ready_ones); end
    total++; if (cnt_at_last !== 8'd255) begin bad++; $display("FAIL b2b_cnt255: got %0d want 255", cnt_at_last); end
    total++; if (xfer_count !== 8'd0) begin bad++; $display("FAIL b2b_wrap: got %0d want 0", xfer_count); end
    total++; if (ei_edges - e0 !== 256 || regq[1] !== 8'hC3)
      begin bad++; $display("FAIL b2b_ei: got edges=%0d reg1=%h want 256 c3", ei_edges - e0, regq[1]); end
    total++; if (multihot - mh0 !== 0) begin bad++; $display("FAIL b2b_onehot: got %0d want 0", multihot - mh0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tb_init = 1'b1; reset = 1'b1;
    req_valid = 1'b0; req_src = '0; req_dst = '0; req_rd_only = 1'b0;
    d3_req_valid = 1'b0; d3_req_src = '0; d3_req_dst = '0; d3_req_rd_only = 1'b0;
    for (int k = 0; k < 4; k++) src_val[k] = 8'h00;
    #1;
    test_reset();
    test_write();
    test_read_only();
    test_same_src_dst();
    test_err();
    test_reset_mid_latch();
    test_back_to_back();
    total++; if (multihot !== 0) begin bad++; $display("FAIL onehot_all: got %0d want 0", multihot); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
